// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package sevenseg_pkg;

    // Segment bus {a,b,c,d,e,f,g} with a in bit 6, active-high.
    typedef logic [6:0] seg_t;

    // All segments off.
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Width of a counter that indexes 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to seven-segment glyph decoder, segments {a..g} with a = bit 6.
module hex_to_7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Standard hex glyphs; lowercase shapes for b and d keep them distinct from 8 and 0.
    always_comb begin
        seg = 7'b0000000;
        case (nibble)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller.
// A prescaler sets how long each digit stays lit; new values are taken over a
// valid/ready handshake into a staging register and only copied to the shown
// value at a frame boundary, so a frame never mixes old and new digits.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant non-zero nibble (digit 0 always shown).
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    disp_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_tick
);

    import sevenseg_pkg::*;

    localparam int IDX_W  = idx_width(NUM_DIGITS);
    localparam int PCNT_W = idx_width(REFRESH_DIV);
    localparam int VAL_W  = 4 * NUM_DIGITS;

    logic [PCNT_W-1:0] pcnt;
    logic [IDX_W-1:0]  idx;
    logic [VAL_W-1:0]  display;
    logic [VAL_W-1:0]  staging;
    logic              pending;

    logic              pcnt_wrap;
    logic              idx_wrap;
    logic              boundary;
    logic              transfer;
    logic [3:0]        nibble;
    logic [6:0]        glyph;
    logic              blank;

    assign pcnt_wrap = (pcnt == PCNT_W'(REFRESH_DIV - 1));
    assign idx_wrap  = (idx == IDX_W'(NUM_DIGITS - 1));
    assign boundary  = pcnt_wrap && idx_wrap;

    // Ready is forced high during reset so upstream never sees a stale stall.
    assign load_ready = !pending || rst;
    assign transfer   = load_valid && !pending;

    // Select the nibble of the committed value belonging to the active digit.
    always_comb begin
        nibble = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nibble = display[4*k +: 4];
            end
        end
    end

    hex_to_7seg u_dec (
        .nibble (nibble),
        .seg    (glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;

    // Find the most significant non-zero digit; digit 0 is the floor so 0 shows "0".
    always_comb begin
        msd = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (display[4*k +: 4] != 4'h0) begin
                msd = IDX_W'(k);
            end
        end
        blank = (idx > msd);
    end
`else
    assign blank = 1'b0;
`endif

    // Prescaler and digit index; free-running, independent of disp_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (pcnt_wrap) begin
            pcnt <= '0;
            idx  <= idx_wrap ? '0 : idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Handshake into staging and commit to display at a frame boundary.
    // A transfer only happens with pending low, so it can never collide with a
    // commit; a value taken on a boundary cycle waits for the next boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            staging <= '0;
            display <= '0;
            pending <= 1'b0;
        end else if (transfer) begin
            staging <= value_in;
            pending <= 1'b1;
        end else if (boundary && pending) begin
            display <= staging;
            pending <= 1'b0;
        end
    end

    // Registered output stage: digit enable, segment bus and frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= '0;
            seg        <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (!disp_en || blank) begin
                an  <= '0;
                seg <= SEG_BLANK;
            end else begin
                an  <= NUM_DIGITS'(1) << idx;
                seg <= glyph;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Testbench for sevenseg_scan_ctrl with NUM_DIGITS = 4, REFRESH_DIV = 4.
// Honours LEADING_ZERO_BLANK_EN for the blanked-digit expectations.
module tb_sevenseg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = 16'h0000;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        disp_en = 1'b1;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    int xfers    = 0;
    int x0       = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } slot_t;

    slot_t      tab_12af [4];
    slot_t      tab_0050 [4];
    logic [6:0] glyph    [16];

    always #5 clk = ~clk;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .disp_en    (disp_en),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    // Count accepted handshakes as seen on the bus.
    always @(posedge clk) begin
        if (!rst && load_valid && load_ready) xfers <= xfers + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    // Digit shown after edge tt (edges counted from 1 after reset release).
    function automatic int digit_of(input int tt);
        return ((tt - 1) / RD) % ND;
    endfunction

    task automatic exp_slot(input logic [15:0] v, input int d,
                            output logic [3:0] ea, output logic [6:0] es);
        logic [3:0] nib;
        int         msd;
        logic [3:0] one;
        nib = v[4*d +: 4];
        msd = 0;
        for (int k = 1; k < ND; k++) if (v[4*k +: 4] != 4'h0) msd = k;
        one = 4'b0001;
        ea  = one << d;
        es  = glyph[nib];
`ifdef LEADING_ZERO_BLANK_EN
        if (d > msd) begin
            ea = 4'b0000;
            es = 7'b0000000;
        end
`endif
    endtask

    task automatic run_scan(input int n, input logic [15:0] v, input string tag);
        logic [3:0] ea;
        logic [6:0] es;
        for (int i = 0; i < n; i++) begin
            tick();
            exp_slot(v, digit_of(t), ea, es);
            chk({tag, "_an"}, 32'(an), 32'(ea));
            chk({tag, "_seg"}, 32'(seg), 32'(es));
            chk({tag, "_frame_tick"}, 32'(frame_tick), 32'((t % (ND*RD)) == 0));
        end
    endtask

    task automatic run_table(input slot_t tab [4], input string tag);
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < RD; k++) begin
                tick();
                chk({tag, "_an"}, 32'(an), 32'(tab[d].an));
                chk({tag, "_seg"}, 32'(seg), 32'(tab[d].seg));
                chk({tag, "_frame_tick"}, 32'(frame_tick), 32'((t % (ND*RD)) == 0));
            end
        end
    endtask

    initial begin
        glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000; glyph[2]  = 7'b1101101;
        glyph[3]  = 7'b1111001; glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011;
        glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000; glyph[8]  = 7'b1111111;
        glyph[9]  = 7'b1111011; glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
        glyph[12] = 7'b1001110; glyph[13] = 7'b0111101; glyph[14] = 7'b1001111;
        glyph[15] = 7'b1000111;

        tab_12af[0] = '{4'b0001, 7'b1000111};
        tab_12af[1] = '{4'b0010, 7'b1110111};
        tab_12af[2] = '{4'b0100, 7'b1101101};
        tab_12af[3] = '{4'b1000, 7'b0110000};

        tab_0050[0] = '{4'b0001, 7'b1111110};
        tab_0050[1] = '{4'b0010, 7'b1011011};
`ifdef LEADING_ZERO_BLANK_EN
        tab_0050[2] = '{4'b0000, 7'b0000000};
        tab_0050[3] = '{4'b0000, 7'b0000000};
`else
        tab_0050[2] = '{4'b0100, 7'b1111110};
        tab_0050[3] = '{4'b1000, 7'b1111110};
`endif

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_an", 32'(an), 32'h0);
            chk("rst_seg", 32'(seg), 32'h0);
            chk("rst_ready", 32'(load_ready), 32'h1);
            chk("rst_frame_tick", 32'(frame_tick), 32'h0);
        end
        rst = 1'b0;
        t   = 0;

        // First edge after release.
        tick();
        chk("first_an", 32'(an), 32'h1);
        chk("first_seg", 32'(seg), 32'(7'b1111110));
        chk("first_ready", 32'(load_ready), 32'h1);
        run_scan(19, 16'h0000, "zero");                     // t = 20

        // Load 12AF mid-frame; old digits until the boundary at t = 32.
        value_in   = 16'h12AF;
        load_valid = 1'b1;
        tick();                                             // t = 21
        load_valid = 1'b0;
        chk("load_ready_fall", 32'(load_ready), 32'h0);
        run_scan(10, 16'h0000, "old_digits");               // t = 31
        chk("ready_before_commit", 32'(load_ready), 32'h0);
        run_scan(1, 16'h0000, "old_digits");                // t = 32
        chk("ready_after_commit", 32'(load_ready), 32'h1);
        run_table(tab_12af, "v12af");                       // t = 48

        // Back-to-back: 0003 pending, 5555 held until ready rises.
        run_scan(2, 16'h12AF, "v12af_tail");                // t = 50
        value_in   = 16'h0003;
        load_valid = 1'b1;
        tick();                                             // t = 51
        load_valid = 1'b0;
        run_scan(1, 16'h12AF, "v12af_tail");                // t = 52
        value_in   = 16'h5555;
        load_valid = 1'b1;
        x0         = xfers;
        for (int i = 0; i < 11; i++) begin                  // t = 53..63
            tick();
            chk("held_ready_low", 32'(load_ready), 32'h0);
        end
        chk("held_no_xfer", 32'(xfers), 32'(x0));
        tick();                                             // t = 64
        chk("held_ready_rise", 32'(load_ready), 32'h1);
        tick();                                             // t = 65
        load_valid = 1'b0;
        chk("held_accept_ready", 32'(load_ready), 32'h0);
        chk("held_accept_once", 32'(xfers), 32'(x0 + 1));
        run_scan(15, 16'h0003, "v0003");                    // t = 80
        chk("held_once_total", 32'(xfers), 32'(x0 + 1));
        chk("held_commit_ready", 32'(load_ready), 32'h1);

        // Transfer on a boundary cycle waits one more frame.
        run_scan(15, 16'h5555, "v5555");                    // t = 95
        value_in   = 16'hA000;
        load_valid = 1'b1;
        tick();                                             // t = 96
        load_valid = 1'b0;
        chk("bnd_ready", 32'(load_ready), 32'h0);
        run_scan(16, 16'h5555, "bnd_hold");                 // t = 112
        chk("bnd_commit_ready", 32'(load_ready), 32'h1);
        run_scan(18, 16'hA000, "vA000");                    // t = 130

        // Display disabled for ten cycles; the scan keeps running.
        disp_en = 1'b0;
        for (int i = 0; i < 10; i++) begin                  // t = 131..140
            tick();
            chk("dark_an", 32'(an), 32'h0);
            chk("dark_seg", 32'(seg), 32'h0);
        end
        disp_en = 1'b1;
        tick();                                             // t = 141
        chk("resume_an", 32'(an), 32'(4'b1000));
        chk("resume_seg", 32'(seg), 32'(7'b1110111));
        run_scan(3, 16'hA000, "vA000_resume");              // t = 144

        // 0050: leading-zero behaviour on digits 3 and 2.
        value_in   = 16'h0050;
        load_valid = 1'b1;
        tick();                                             // t = 145
        load_valid = 1'b0;
        run_scan(15, 16'hA000, "vA000_tail");               // t = 160
        run_table(tab_0050, "v0050");                       // t = 176

        // Reset mid-frame with a value pending.
        run_scan(4, 16'h0050, "v0050_tail");                // t = 180
        value_in   = 16'h0007;
        load_valid = 1'b1;
        tick();                                             // t = 181
        load_valid = 1'b0;
        run_scan(4, 16'h0050, "v0050_pend");                // t = 185
        chk("pend_ready", 32'(load_ready), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_an", 32'(an), 32'h0);
        chk("mid_rst_seg", 32'(seg), 32'h0);
        chk("mid_rst_ready", 32'(load_ready), 32'h1);
        chk("mid_rst_frame_tick", 32'(frame_tick), 32'h0);
        rst = 1'b0;
        t   = 0;
        tick();                                             // t = 1
        chk("restart_an", 32'(an), 32'h1);
        chk("restart_seg", 32'(seg), 32'(7'b1111110));
        chk("restart_ready", 32'(load_ready), 32'h1);
        run_scan(16, 16'h0000, "after_rst");                // t = 17, pending 7 must not appear

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout t=%0d actual=running required=finished", t);
        $fatal(1, "timeout");
    end

endmodule
